// File: rtl/game_state_ctrl_pkg.sv
// Shared definitions for the crossing game: grid geometry, row roles, round states
// and the two-digit BCD increment used by every score/timer counter.
package game_state_ctrl_pkg;

  localparam int GRID_W_DEFAULT = 21;
  localparam int GRID_H         = 15;

  localparam logic [3:0] GOAL_ROW   = 4'd0;
  localparam logic [3:0] START_ROW  = 4'(GRID_H - 1);
  localparam logic [3:0] LANE_FIRST = 4'd1;
  localparam logic [3:0] LANE_LAST  = START_ROW - 4'd1;

  localparam logic [2:0] LEVEL_MAX = 3'd7;
  localparam logic [7:0] BCD_MAX   = 8'h99;
  localparam logic [1:0] GUARD_INIT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_HIT       = 3'd2,
    ST_SCORE     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  // Units wrap 9->0 with carry into tens; 99 holds.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] value);
    logic [7:0] next;
    if (value == BCD_MAX) begin
      next = value;
    end else if (value[3:0] == 4'd9) begin
      next = {value[7:4] + 4'd1, 4'd0};
    end else begin
      next = {value[7:4], value[3:0] + 4'd1};
    end
    return next;
  endfunction

endpackage

// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD counter, saturating at 99. Shared by the score display and the
// 7-segment timer.
module bcd_counter_2digit
  import game_state_ctrl_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_inc,
  output logic [7:0] o_value
);

  // NOTE: sequential state is always assigned with <= so every reader in the
  // same edge sees the pre-edge value.
  always_ff @(posedge i_Clk) begin
    if (i_reset || i_clear) begin
      o_value <= 8'h00;
    end else if (i_inc) begin
      o_value <= bcd_inc_sat(o_value);
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Round controller: samples the player's row occupancy, detects goal/collision,
// and sequences IDLE/PLAY/HIT/SCORE/GAME_OVER with lives, BCD score and level.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int GRID_W            = GRID_W_DEFAULT,
  parameter int START_LIVES       = 3,
  parameter int FLASH_CYCLES      = 25_000_000,
  parameter int SCORE_HOLD_CYCLES = 12_500_000,
  parameter int LEVEL_STEP        = 5
) (
  input  logic              i_Clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [4:0]        i_player_x,
  input  logic [3:0]        i_player_y,
  input  logic [GRID_W-1:0] i_row_mask,
  output logic [3:0]        o_query_row,
  output logic              o_player_reset,
  output logic [1:0]        o_lives,
  output logic [7:0]        o_score,
  output logic [2:0]        o_level,
  output logic [2:0]        o_state,
  output logic              o_flash
);

  localparam int TIMER_MAX = (FLASH_CYCLES > SCORE_HOLD_CYCLES) ? FLASH_CYCLES : SCORE_HOLD_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int CROSS_W   = $clog2(LEVEL_STEP + 1);

  localparam logic [TIMER_W-1:0] FLASH_LAST = TIMER_W'(FLASH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(SCORE_HOLD_CYCLES - 1);
  localparam logic [CROSS_W-1:0] CROSS_LAST = CROSS_W'(LEVEL_STEP - 1);
  localparam logic [1:0]         LIVES_INIT = 2'(START_LIVES);

  state_e               r_state;
  logic                 r_start;
  logic [TIMER_W-1:0]   r_timer;
  logic [1:0]           r_guard;
  logic                 r_valid;
  logic [4:0]           r_q_x;
  logic [3:0]           r_q_y;
  logic [CROSS_W-1:0]   r_cross;

  logic w_s_start;
  logic w_mask_bit;
  logic w_in_lane;
  logic w_x_in_grid;
  logic w_goal;
  logic w_hit;
  logic w_score_inc;
  logic w_score_clr;

  assign w_s_start = i_start & ~r_start;

  // Shifting past the top bit yields zero, so out-of-grid columns read as free.
  assign w_mask_bit  = |(i_row_mask & (GRID_W'(1) << r_q_x));
  assign w_in_lane   = (r_q_y >= LANE_FIRST) && (r_q_y <= LANE_LAST);
  assign w_x_in_grid = 32'(r_q_x) < GRID_W;

  assign w_goal = r_valid && (r_q_y == GOAL_ROW);
  assign w_hit  = r_valid && w_in_lane && w_x_in_grid && w_mask_bit;

  assign w_score_inc = (r_state == ST_PLAY) && w_goal;
  assign w_score_clr = (r_state == ST_GAME_OVER) && w_s_start;

  assign o_state = r_state;

  bcd_counter_2digit u_score (
    .i_Clk   (i_Clk),
    .i_reset (i_reset),
    .i_clear (w_score_clr),
    .i_inc   (w_score_inc),
    .o_value (o_score)
  );

  always_ff @(posedge i_Clk) begin
    // A start button held through reset must not count as a press afterwards.
    r_start <= i_start;

    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_guard        <= '0;
      r_valid        <= 1'b0;
      r_q_x          <= '0;
      r_q_y          <= '0;
      r_cross        <= '0;
      o_query_row    <= '0;
      o_player_reset <= 1'b0;
      o_lives        <= LIVES_INIT;
      o_level        <= '0;
      o_flash        <= 1'b0;
    end else begin
      o_player_reset <= 1'b0;

      // Outside PLAY the guard is held armed, so every entry starts suppressed.
      if (r_state != ST_PLAY) begin
        r_guard <= GUARD_INIT;
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_s_start) begin
            o_player_reset <= 1'b1;
            r_timer        <= '0;
            r_state        <= ST_PLAY;
          end
        end

        ST_PLAY: begin
          r_q_x       <= i_player_x;
          r_q_y       <= i_player_y;
          o_query_row <= i_player_y;
          r_valid     <= (r_guard == 2'd0);
          if (r_guard != 2'd0) begin
            r_guard <= r_guard - 2'd1;
          end

          if (w_goal) begin
            r_timer <= '0;
            r_state <= ST_SCORE;
            if (r_cross == CROSS_LAST) begin
              r_cross <= '0;
              if (o_level != LEVEL_MAX) begin
                o_level <= o_level + 3'd1;
              end
            end else begin
              r_cross <= r_cross + CROSS_W'(1);
            end
          end else if (w_hit) begin
            r_timer <= '0;
            r_state <= ST_HIT;
            o_flash <= 1'b1;
            if (o_lives != 2'd0) begin
              o_lives <= o_lives - 2'd1;
            end
          end
        end

        ST_HIT: begin
          if (r_timer == FLASH_LAST) begin
            r_timer <= '0;
            if (o_lives == 2'd0) begin
              r_state <= ST_GAME_OVER;
            end else begin
              o_flash        <= 1'b0;
              o_player_reset <= 1'b1;
              r_state        <= ST_PLAY;
            end
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end

        ST_SCORE: begin
          if (r_timer == HOLD_LAST) begin
            r_timer        <= '0;
            o_player_reset <= 1'b1;
            r_state        <= ST_PLAY;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end

        ST_GAME_OVER: begin
          if (w_s_start) begin
            o_lives        <= LIVES_INIT;
            o_level        <= '0;
            r_cross        <= '0;
            o_flash        <= 1'b0;
            o_player_reset <= 1'b1;
            r_timer        <= '0;
            r_state        <= ST_PLAY;
          end
        end

        default: begin
          r_timer <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed + randomized bench for game_state_ctrl; expectations come from an
// event-level model of lives, score, level and reset pulses.
module tb_game_state_ctrl;

  localparam int GRID_W = 21;
  localparam int FLASH  = 8;
  localparam int HOLD   = 4;
  localparam int STEP   = 2;
  localparam int LIVES0 = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4:0]        px;
  logic [3:0]        py;
  logic [GRID_W-1:0] mask;
  logic [3:0]        q_row;
  logic              p_reset;
  logic [1:0]        lives;
  logic [7:0]        score;
  logic [2:0]        level;
  logic [2:0]        state;
  logic              flash;

  logic [GRID_W-1:0] lane [0:15];

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int m_lives, m_score, m_level, m_cross, m_pulses;

  game_state_ctrl #(
    .GRID_W            (GRID_W),
    .START_LIVES       (LIVES0),
    .FLASH_CYCLES      (FLASH),
    .SCORE_HOLD_CYCLES (HOLD),
    .LEVEL_STEP        (STEP)
  ) dut (
    .i_Clk          (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_player_x     (px),
    .i_player_y     (py),
    .i_row_mask     (mask),
    .o_query_row    (q_row),
    .o_player_reset (p_reset),
    .o_lives        (lives),
    .o_score        (score),
    .o_level        (level),
    .o_state        (state),
    .o_flash        (flash)
  );

  always #5 clk = ~clk;

  // Lane stage stand-in: answers the queried row one half-cycle later.
  always @(negedge clk) begin
    mask = lane[q_row];
    if (p_reset) pulse_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic set_pos(input int x, input int y);
    px = 5'(x);
    py = 4'(y);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_lives"}, 32'(lives), 32'(m_lives));
    check({tag, "_score"}, 32'(score), 32'(to_bcd(m_score)));
    check({tag, "_level"}, 32'(level), 32'(m_level));
  endtask

  // Expects PLAY with the guard already elapsed; returns the same way unless lives run out.
  task automatic hit_event(input int x, input int y);
    lane[y]    = GRID_W'($urandom);
    lane[y][x] = 1'b1;
    set_pos(x, y);
    tick;
    check("hit_lat_state", 32'(state), 32'd1);
    check("hit_qrow", 32'(q_row), 32'(y));
    tick;
    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    check("hit_state", 32'(state), 32'd2);
    check("hit_flash", 32'(flash), 32'd1);
    check_model("hit");
    set_pos(x, 14);
    for (int i = 1; i < FLASH; i++) begin
      tick;
      check("hit_hold_state", 32'(state), 32'd2);
      check("hit_hold_flash", 32'(flash), 32'd1);
    end
    tick;
    if (m_lives == 0) begin
      check("over_state", 32'(state), 32'd4);
      check("over_flash", 32'(flash), 32'd1);
      check("over_no_pulse", 32'(p_reset), 32'd0);
    end else begin
      m_pulses++;
      check("hit_ret_state", 32'(state), 32'd1);
      check("hit_ret_pulse", 32'(p_reset), 32'd1);
      check("hit_ret_flash", 32'(flash), 32'd0);
      tick;
      check("hit_pulse_1cyc", 32'(p_reset), 32'd0);
      tick;
    end
  endtask

  task automatic goal_event(input int x);
    set_pos(x, 0);
    tick;
    check("goal_lat_state", 32'(state), 32'd1);
    tick;
    m_score = (m_score < 99) ? m_score + 1 : 99;
    m_cross++;
    if (m_cross == STEP) begin
      m_cross = 0;
      if (m_level < 7) m_level++;
    end
    check("goal_state", 32'(state), 32'd3);
    check_model("goal");
    set_pos(x, 14);
    for (int i = 1; i < HOLD; i++) begin
      tick;
      check("score_hold_state", 32'(state), 32'd3);
    end
    tick;
    m_pulses++;
    check("score_ret_state", 32'(state), 32'd1);
    check("score_ret_pulse", 32'(p_reset), 32'd1);
    tick;
    check("score_pulse_1cyc", 32'(p_reset), 32'd0);
    tick;
  endtask

  task automatic safe_probe();
    int x, y;
    y = $urandom_range(13, 1);
    x = $urandom_range(20, 1);
    lane[y]    = GRID_W'($urandom);
    lane[y][x] = 1'b0;
    set_pos(x, y);
    tick;
    check("probe_qrow", 32'(q_row), 32'(y));
    tick;
    tick;
    check("probe_state", 32'(state), 32'd1);
    check("probe_lives", 32'(lives), 32'(m_lives));
  endtask

  task automatic no_hit_at(input string tag, input int x, input int y);
    set_pos(x, y);
    repeat (3) tick;
    check(tag, 32'(state), 32'd1);
    check({tag, "_lives"}, 32'(lives), 32'(m_lives));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_pos(10, 14);
    for (int r = 0; r < 16; r++) lane[r] = '0;
    m_lives = LIVES0; m_score = 0; m_level = 0; m_cross = 0; m_pulses = 0;

    tick;
    tick;
    check("rst_state", 32'(state), 32'd0);
    check_model("rst");
    check("rst_qrow", 32'(q_row), 32'd0);
    check("rst_flash", 32'(flash), 32'd0);
    check("rst_pulse", 32'(p_reset), 32'd0);
    rst = 1'b0;
    tick;
    check("idle_hold", 32'(state), 32'd0);

    // Start from IDLE, then a hazard during the two guard cycles.
    start = 1'b1;
    tick;
    m_pulses++;
    check("start_state", 32'(state), 32'd1);
    check("start_pulse", 32'(p_reset), 32'd1);
    check_model("start");
    start = 1'b0;
    lane[5] = '1;
    set_pos(7, 5);
    tick;
    check("start_pulse_1cyc", 32'(p_reset), 32'd0);
    tick;
    set_pos(7, 14);
    repeat (4) begin
      tick;
      check("guard_state", 32'(state), 32'd1);
    end
    check_model("guard");

    hit_event(7, 5);
    goal_event($urandom_range(20, 1));
    goal_event($urandom_range(20, 1));

    lane[14] = '1;
    no_hit_at("nohit_start_row", $urandom_range(20, 1), 14);
    lane[5] = '1;
    no_hit_at("nohit_x21", 21, 5);
    no_hit_at("nohit_xhigh", $urandom_range(31, 22), 5);

    start = 1'b1;
    tick;
    tick;
    check("play_ignores_start", 32'(state), 32'd1);
    check("play_start_no_pulse", 32'(p_reset), 32'd0);
    start = 1'b0;
    tick;

    for (int n = 0; n < 99; n++) begin
      safe_probe();
      goal_event($urandom_range(20, 1));
    end
    check("score_saturated", 32'(score), 32'h99);
    check("level_saturated", 32'(level), 32'd7);

    while (m_lives > 0) hit_event($urandom_range(20, 1), $urandom_range(13, 1));
    tick;
    check("over_hold_state", 32'(state), 32'd4);
    check("over_hold_flash", 32'(flash), 32'd1);

    start = 1'b1;
    tick;
    m_pulses++;
    m_lives = LIVES0; m_score = 0; m_level = 0; m_cross = 0;
    check("restart_state", 32'(state), 32'd1);
    check("restart_pulse", 32'(p_reset), 32'd1);
    check("restart_flash", 32'(flash), 32'd0);
    check_model("restart");
    start = 1'b0;
    set_pos(3, 14);
    tick;
    tick;
    goal_event($urandom_range(20, 1));

    // Reset lands while HIT's timer reads 3.
    lane[9]    = '0;
    lane[9][4] = 1'b1;
    set_pos(4, 9);
    tick;
    tick;
    m_lives--;
    check("rhit_state", 32'(state), 32'd2);
    check("rhit_lives", 32'(lives), 32'(m_lives));
    set_pos(4, 14);
    repeat (3) tick;
    rst   = 1'b1;
    start = 1'b1;
    tick;
    m_lives = LIVES0; m_score = 0; m_level = 0; m_cross = 0;
    check("rhit_state_idle", 32'(state), 32'd0);
    check("rhit_flash", 32'(flash), 32'd0);
    check("rhit_no_pulse", 32'(p_reset), 32'd0);
    check_model("rhit");
    tick;
    rst = 1'b0;
    tick;
    tick;
    check("held_start_ignored", 32'(state), 32'd0);
    start = 1'b0;
    tick;
    start = 1'b1;
    tick;
    m_pulses++;
    check("fresh_start_state", 32'(state), 32'd1);
    check("fresh_start_pulse", 32'(p_reset), 32'd1);
    start = 1'b0;
    tick;
    tick;
    check("pulse_total", 32'(pulse_cnt), 32'(m_pulses));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
